mmio_bridge: RTL

- Sits between the miniCPU data-memory port and the DRAM/board peripherals.
- Decodes every CPU data access as either DRAM or a memory-mapped peripheral register:
  - 7-seg display data, LED register, synchronised switches/buttons, a prescaled timer.
- Drives the display module's 32-bit data word in place of a hard-wired debug register.
- Single-cycle-CPU compatible: combinational read path, registered writes.

---
 rtl/mmio_map_pkg.sv | 21 ++
 rtl/io_timer.sv | 60 ++++++
 rtl/mmio_bridge.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mmio_map_pkg.sv
// rtl/mmio_map_pkg.sv - address map and width constants for the CPU MMIO bridge
//
// Purpose: shared peripheral register addresses, the default peripheral base,
//          and the widths of the LED/switch/button registers.
// Ports:   none (package).
package mmio_map_pkg;

    localparam logic [31:0] DEF_PERIPH_BASE = 32'hFFFF_F000;

    localparam logic [31:0] ADR_DISP = 32'hFFFF_F000;
    localparam logic [31:0] ADR_TCNT = 32'hFFFF_F020;
    localparam logic [31:0] ADR_TDIV = 32'hFFFF_F024;
    localparam logic [31:0] ADR_LED  = 32'hFFFF_F060;
    localparam logic [31:0] ADR_SW   = 32'hFFFF_F070;
    localparam logic [31:0] ADR_BTN  = 32'hFFFF_F078;

    localparam int LED_W = 24;
    localparam int SW_W  = 24;
    localparam int BTN_W = 5;

endpackage

// File: rtl/io_timer.sv
// rtl/io_timer.sv - prescaled free-running timer with writable count and divisor
//
// Purpose: prescaler counter r_pre advances every clock while the divisor is
//          non-zero; each time it reaches divisor-1 the count advances by one.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_div_we        write strobe for the divisor (also clears the prescaler)
//   i_cnt_we        write strobe for the count
//   i_wdata         write data shared by both strobes
//   o_tcnt          current count
//   o_tdiv          current divisor (0 halts the timer)
module io_timer #(
    parameter logic [31:0] DEFAULT_DIV = 32'd25_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_div_we,
    input  logic        i_cnt_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_tcnt,
    output logic [31:0] o_tdiv
);

    logic [31:0] r_pre;
    logic [31:0] r_tcnt;
    logic [31:0] r_tdiv;
    logic        w_run;
    logic        w_tick;

    assign w_run  = (r_tdiv != 32'd0);
    assign w_tick = w_run && (r_pre == r_tdiv - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= 32'd0;
            r_tcnt <= 32'd0;
            r_tdiv <= DEFAULT_DIV;
        end else begin
            // Clearing the prescaler on a divisor write means a new divisor
            // below the current prescaler value can never be skipped past.
            if (i_div_we) begin
                r_tdiv <= i_wdata;
                r_pre  <= 32'd0;
            end else if (w_run) begin
                r_pre  <= w_tick ? 32'd0 : r_pre + 32'd1;
            end

            // A software write to the count overrides a coincident tick.
            if (i_cnt_we) begin
                r_tcnt <= i_wdata;
            end else if (w_tick) begin
                r_tcnt <= r_tcnt + 32'd1;
            end
        end
    end

    assign o_tcnt = r_tcnt;
    assign o_tdiv = r_tdiv;

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - splits CPU data accesses between DRAM and board peripherals
//
// Purpose: decodes each CPU data access; addresses at or above PERIPH_BASE hit
//          the peripheral registers (display word, LEDs, synchronised switches
//          and buttons, prescaled timer) and never reach DRAM.  Reads are
//          combinational, writes land on the rising clock edge.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_adr/cpu_wdin/cpu_we     CPU data-port address, write data, write enable
//   cpu_rd                      read data back to the CPU
//   dram_adr/dram_wdin/dram_we  DRAM port (address/data pass through, we gated)
//   dram_rd                     DRAM read data
//   sw_i/btn_i                  raw asynchronous switches and buttons
//   led_o                       LED register
//   disp_o                      32-bit word for the seven-segment display
module mmio_bridge
    import mmio_map_pkg::*;
#(
    parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE,
    parameter logic [31:0] DEFAULT_DIV = 32'd25_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cpu_adr,
    input  logic [31:0]      cpu_wdin,
    input  logic             cpu_we,
    output logic [31:0]      cpu_rd,
    output logic [31:0]      dram_adr,
    output logic [31:0]      dram_wdin,
    output logic             dram_we,
    input  logic [31:0]      dram_rd,
    input  logic [SW_W-1:0]  sw_i,
    input  logic [BTN_W-1:0] btn_i,
    output logic [LED_W-1:0] led_o,
    output logic [31:0]      disp_o
);

    logic             w_is_periph;
    logic             w_wr;
    logic             w_wr_disp;
    logic             w_wr_led;
    logic             w_wr_tcnt;
    logic             w_wr_tdiv;
    logic [31:0]      w_tcnt;
    logic [31:0]      w_tdiv;
    logic [31:0]      w_rd;

    logic [31:0]      r_disp;
    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sw_sync  [SYNC_STAGES];
    logic [BTN_W-1:0] r_btn_sync [SYNC_STAGES];

    // Decode
    assign w_is_periph = (cpu_adr >= PERIPH_BASE);
    assign w_wr        = cpu_we & w_is_periph;
    assign w_wr_disp   = w_wr & (cpu_adr == ADR_DISP);
    assign w_wr_led    = w_wr & (cpu_adr == ADR_LED);
    assign w_wr_tcnt   = w_wr & (cpu_adr == ADR_TCNT);
    assign w_wr_tdiv   = w_wr & (cpu_adr == ADR_TDIV);

    assign dram_adr  = cpu_adr;
    assign dram_wdin = cpu_wdin;
    assign dram_we   = cpu_we & ~w_is_periph;

    // Writable peripheral registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= 32'd0;
            r_led  <= '0;
        end else begin
            if (w_wr_disp) r_disp <= cpu_wdin;
            if (w_wr_led)  r_led  <= cpu_wdin[LED_W-1:0];
        end
    end

    // Input synchronisers: stage 0 samples the raw pin, the last stage is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sw_sync[i]  <= '0;
                r_btn_sync[i] <= '0;
            end
        end else begin
            r_sw_sync[0]  <= sw_i;
            r_btn_sync[0] <= btn_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sw_sync[i]  <= r_sw_sync[i-1];
                r_btn_sync[i] <= r_btn_sync[i-1];
            end
        end
    end

    io_timer #(
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_div_we (w_wr_tdiv),
        .i_cnt_we (w_wr_tcnt),
        .i_wdata  (cpu_wdin),
        .o_tcnt   (w_tcnt),
        .o_tdiv   (w_tdiv)
    );

    // Combinational read path; unmapped peripheral addresses read as zero.
    always_comb begin
        w_rd = 32'd0;
        if (!w_is_periph) begin
            w_rd = dram_rd;
        end else begin
            case (cpu_adr)
                ADR_DISP: w_rd = r_disp;
                ADR_TCNT: w_rd = w_tcnt;
                ADR_TDIV: w_rd = w_tdiv;
                ADR_LED:  w_rd = {{(32-LED_W){1'b0}}, r_led};
                ADR_SW:   w_rd = {{(32-SW_W){1'b0}}, r_sw_sync[SYNC_STAGES-1]};
                ADR_BTN:  w_rd = {{(32-BTN_W){1'b0}}, r_btn_sync[SYNC_STAGES-1]};
                default:  w_rd = 32'd0;
            endcase
        end
    end

    assign cpu_rd = w_rd;
    assign led_o  = r_led;
    assign disp_o = r_disp;

endmodule
